uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: turns SYNC/ADDR/LEN/payload[/CHK] byte frames into register-bank writes.
// Define FRAME_CHECKSUM_EN to buffer the payload and commit it only after a matching checksum.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 137_500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO   = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]    MAXL  = 8'(MAX_LEN);
    localparam logic [1:0]    E_LEN = 2'b01;
    localparam logic [1:0]    E_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_FLUSH
    } state_e;

    state_e state_q, state_d;

    logic [7:0]    base_q, base_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    chk_q, chk_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic          byte_st;
    logic          timeout;
    logic          last_byte;
    logic          len_bad;
    logic          is_sync;

    assign byte_st   = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_PAYLOAD) || (state_q == S_CHK);
    // A byte arriving on the expiry cycle wins over the timeout.
    assign timeout   = byte_st && !rx_valid && (tmo_q == TMO);
    assign last_byte = (idx_q == (len_q - 8'd1));
    assign len_bad   = (rx_data == 8'd0) || (rx_data > MAXL);
    assign is_sync   = rx_valid && (rx_data == SYNC_BYTE);

`ifdef FRAME_CHECKSUM_EN
    localparam int         IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [1:0] E_CHK = 2'b10;

    logic [7:0] buf_q [MAX_LEN];

    always_ff @(posedge clk) begin
        if (state_q == S_PAYLOAD && rx_valid) begin
            buf_q[idx_q[IW-1:0]] <= rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_sync) state_d = S_ADDR;
                end
                S_ADDR: begin
                    if (rx_valid) state_d = S_LEN;
                end
                S_LEN: begin
                    if (rx_valid) state_d = len_bad ? S_IDLE : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    if (rx_valid && last_byte) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_IDLE;
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        state_d = (rx_data == chk_q) ? S_FLUSH : S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (idx_q == len_q) state_d = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        chk_d     = chk_q;
        tmo_d     = byte_st ? (tmo_q + TW'(1)) : '0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;

        if (rx_valid) tmo_d = '0;

        if (timeout) begin
            tmo_d  = '0;
            err_d  = 1'b1;
            code_d = E_TMO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_sync) begin
                        chk_d = 8'd0;
                        idx_d = 8'd0;
                    end
                end
                S_ADDR: begin
                    if (rx_valid) begin
                        base_d = rx_data;
                        chk_d  = rx_data;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (len_bad) begin
                            err_d  = 1'b1;
                            code_d = E_LEN;
                        end else begin
                            len_d = rx_data;
                            chk_d = chk_q ^ rx_data;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (rx_valid) begin
                        chk_d = chk_q ^ rx_data;
                        idx_d = idx_q + 8'd1;
`ifndef FRAME_CHECKSUM_EN
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + idx_q;
                        wr_data_d = rx_data;
                        done_d    = last_byte;
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == chk_q) begin
                            idx_d = 8'd0;
                        end else begin
                            err_d  = 1'b1;
                            code_d = E_CHK;
                        end
                    end
                end
                // One write per cycle; the extra cycle at idx==len carries frame_done.
                S_FLUSH: begin
                    if (idx_q == len_q) begin
                        done_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = base_q + idx_q;
                        wr_data_d = buf_q[idx_q[IW-1:0]];
                        idx_d     = idx_q + 8'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= 8'd0;
            len_q     <= 8'd0;
            idx_q     <= 8'd0;
            chk_q     <= 8'd0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
        end else begin
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign err_code   = code_q;
    // Held through the done/err pulse so busy drops the cycle after it.
    assign busy       = (state_q != S_IDLE) || done_q || err_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames against uart_rx_frame_ctrl.
// Covers both builds; FRAME_CHECKSUM_EN selects the checksum scenarios.
module tb_uart_rx_frame_ctrl;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int         nwr = 0;
    int         nd = 0;
    int         ne = 0;
    int         nboth = 0;
    int         dt = 0;
    int         et = 0;
    logic [7:0] wa [64];
    logic [7:0] wd [64];
    int         wt [64];
    logic       bz [256];

    uart_rx_frame_ctrl #(
        .SYNC_BYTE(8'hA5),
        .MAX_LEN(16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_done(frame_done),
        .frame_err(frame_err),
        .err_code(err_code),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        bz[cyc % 256] = busy;
        if (wr_en) begin
            if (nwr < 64) begin
                wa[nwr] = wr_addr;
                wd[nwr] = wr_data;
                wt[nwr] = cyc;
            end
            nwr++;
        end
        if (frame_done) begin
            dt = cyc;
            nd++;
        end
        if (frame_err) begin
            et = cyc;
            ne++;
        end
        if (frame_done && frame_err) nboth++;
    end

    task automatic send(input logic [7:0] b, output int t);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t        = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr();
        nwr = 0;
        nd  = 0;
        ne  = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got=%b want=0", wr_en); end
        total++; if (wr_addr !== 8'h00) begin bad++; $display("FAIL rst_wr_addr got=%h want=00", wr_addr); end
        total++; if (wr_data !== 8'h00) begin bad++; $display("FAIL rst_wr_data got=%h want=00", wr_data); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", frame_done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", frame_err); end
        total++; if (err_code !== 2'b00) begin bad++; $display("FAIL rst_code got=%b want=00", err_code); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_noise();
        int t;
        clr();
        send(8'h00, t);
        send(8'h5A, t);
        send(8'hFF, t);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL noise_busy got=%b want=0", busy); end
        idle(3);
        total++; if (nwr != 0 || ne != 0 || nd != 0) begin bad++; $display("FAIL noise_events got wr=%0d err=%0d done=%0d want 0/0/0", nwr, ne, nd); end
    endtask

`ifndef FRAME_CHECKSUM_EN
    task automatic test_basic();
        int t;
        int tp [3];
        logic [7:0] ea [3];
        logic [7:0] ed [3];
        ea = '{8'h10, 8'h11, 8'h12};
        ed = '{8'h11, 8'h22, 8'h33};
        clr();
        send(8'hA5, t);
        send(8'h10, t);
        send(8'h03, t);
        send(8'h11, tp[0]);
        send(8'h22, tp[1]);
        send(8'h33, tp[2]);
        idle(4);
        total++; if (nwr != 3) begin bad++; $display("FAIL basic_nwr got=%0d want=3", nwr); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== ed[i] || wt[i] != tp[i] + 1) begin
                bad++;
                $display("FAIL basic_wr%0d got a=%h d=%h t=%0d want a=%h d=%h t=%0d", i, wa[i], wd[i], wt[i], ea[i], ed[i], tp[i] + 1);
            end
        end
        total++; if (nd != 1 || dt != tp[2] + 1) begin bad++; $display("FAIL basic_done got n=%0d t=%0d want n=1 t=%0d", nd, dt, tp[2] + 1); end
        total++; if (bz[(dt + 1) % 256] !== 1'b0 || bz[dt % 256] !== 1'b1) begin bad++; $display("FAIL basic_busy got at_done=%b after=%b want 1/0", bz[dt % 256], bz[(dt + 1) % 256]); end
        total++; if (ne != 0) begin bad++; $display("FAIL basic_err got=%0d want=0", ne); end
    endtask
`else
    task automatic test_chk_ok();
        int t;
        int tc;
        clr();
        send(8'hA5, t);
        send(8'h10, t);
        send(8'h02, t);
        send(8'hAA, t);
        send(8'hBB, t);
        total++; if (nwr != 0) begin bad++; $display("FAIL chk_early_wr got=%0d want=0", nwr); end
        send(8'h03, tc);
        idle(5);
        total++; if (nwr != 2) begin bad++; $display("FAIL chk_nwr got=%0d want=2", nwr); end
        total++; if (wa[0] !== 8'h10 || wd[0] !== 8'hAA || wt[0] != tc + 2) begin bad++; $display("FAIL chk_wr0 got a=%h d=%h t=%0d want a=10 d=aa t=%0d", wa[0], wd[0], wt[0], tc + 2); end
        total++; if (wa[1] !== 8'h11 || wd[1] !== 8'hBB || wt[1] != tc + 3) begin bad++; $display("FAIL chk_wr1 got a=%h d=%h t=%0d want a=11 d=bb t=%0d", wa[1], wd[1], wt[1], tc + 3); end
        total++; if (nd != 1 || dt != tc + 4) begin bad++; $display("FAIL chk_done got n=%0d t=%0d want n=1 t=%0d", nd, dt, tc + 4); end
        total++; if (bz[(dt + 1) % 256] !== 1'b0) begin bad++; $display("FAIL chk_busy got=%b want=0", bz[(dt + 1) % 256]); end
    endtask

    task automatic test_chk_bad();
        int t;
        int tc;
        clr();
        send(8'hA5, t);
        send(8'h10, t);
        send(8'h02, t);
        send(8'hAA, t);
        send(8'hBB, t);
        send(8'h04, tc);
        idle(5);
        total++; if (nwr != 0) begin bad++; $display("FAIL chkbad_nwr got=%0d want=0", nwr); end
        total++; if (ne != 1 || et != tc + 1) begin bad++; $display("FAIL chkbad_err got n=%0d t=%0d want n=1 t=%0d", ne, et, tc + 1); end
        total++; if (err_code !== 2'b10) begin bad++; $display("FAIL chkbad_code got=%b want=10", err_code); end
        total++; if (bz[(et + 1) % 256] !== 1'b0) begin bad++; $display("FAIL chkbad_busy got=%b want=0", bz[(et + 1) % 256]); end
        total++; if (nd != 0) begin bad++; $display("FAIL chkbad_done got=%0d want=0", nd); end
    endtask
`endif

    task automatic test_wrap();
        int t;
        logic [7:0] ea [3];
        ea = '{8'hFE, 8'hFF, 8'h00};
        clr();
        send(8'hA5, t);
        send(8'hFE, t);
        send(8'h03, t);
        send(8'h01, t);
        send(8'h02, t);
        send(8'h03, t);
`ifdef FRAME_CHECKSUM_EN
        send(8'hFD, t);
`endif
        idle(6);
        total++; if (nwr != 3) begin bad++; $display("FAIL wrap_nwr got=%0d want=3", nwr); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (wa[i] !== ea[i] || wd[i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL wrap_wr%0d got a=%h d=%h want a=%h d=%h", i, wa[i], wd[i], ea[i], 8'(i + 1));
            end
        end
        total++; if (nd != 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", nd); end
    endtask

    task automatic test_len_err();
        int t;
        int tl;
        logic [7:0] lens [2];
        lens = '{8'h00, 8'h11};
        for (int k = 0; k < 2; k++) begin
            clr();
            send(8'hA5, t);
            send(8'h10, t);
            send(lens[k], tl);
            idle(4);
            total++; if (ne != 1 || et != tl + 1) begin bad++; $display("FAIL len%h_err got n=%0d t=%0d want n=1 t=%0d", lens[k], ne, et, tl + 1); end
            total++; if (err_code !== 2'b01) begin bad++; $display("FAIL len%h_code got=%b want=01", lens[k], err_code); end
            total++; if (nwr != 0 || nd != 0) begin bad++; $display("FAIL len%h_wr got wr=%0d done=%0d want 0/0", lens[k], nwr, nd); end
        end
        clr();
        send(8'hA5, t);
        send(8'h20, t);
        send(8'h01, t);
        send(8'h5C, t);
`ifdef FRAME_CHECKSUM_EN
        send(8'h7D, t);
`endif
        idle(5);
        total++; if (nwr != 1 || wa[0] !== 8'h20 || wd[0] !== 8'h5C) begin bad++; $display("FAIL len_recover_wr got n=%0d a=%h d=%h want n=1 a=20 d=5c", nwr, wa[0], wd[0]); end
        total++; if (nd != 1 || ne != 0) begin bad++; $display("FAIL len_recover_done got done=%0d err=%0d want 1/0", nd, ne); end
        total++; if (err_code !== 2'b01) begin bad++; $display("FAIL len_recover_code got=%b want=01", err_code); end
    endtask

    task automatic test_timeout();
        int t;
        int ta;
        clr();
        send(8'hA5, t);
        send(8'h10, ta);
        idle(TO + 10);
        total++; if (ne != 1 || et != ta + TO + 2) begin bad++; $display("FAIL tmo_err got n=%0d t=%0d want n=1 t=%0d", ne, et, ta + TO + 2); end
        total++; if (err_code !== 2'b11) begin bad++; $display("FAIL tmo_code got=%b want=11", err_code); end
        total++; if (nwr != 0 || bz[(et + 1) % 256] !== 1'b0) begin bad++; $display("FAIL tmo_after got wr=%0d busy=%b want 0/0", nwr, bz[(et + 1) % 256]); end
    endtask

    task automatic test_late_byte();
        int t;
        clr();
        send(8'hA5, t);
        send(8'h10, t);
        idle(TO - 1);
        send(8'h01, t);
        send(8'h77, t);
`ifdef FRAME_CHECKSUM_EN
        send(8'h66, t);
`endif
        idle(5);
        total++; if (ne != 0) begin bad++; $display("FAIL late_err got=%0d want=0", ne); end
        total++; if (nwr != 1 || wa[0] !== 8'h10 || wd[0] !== 8'h77 || nd != 1) begin bad++; $display("FAIL late_wr got n=%0d a=%h d=%h done=%0d want n=1 a=10 d=77 done=1", nwr, wa[0], wd[0], nd); end
    endtask

    task automatic test_reset_mid();
        int t;
        clr();
        send(8'hA5, t);
        send(8'h10, t);
        send(8'h04, t);
        send(8'h01, t);
        send(8'h02, t);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (wr_en !== 1'b0 || wr_addr !== 8'h00 || wr_data !== 8'h00) begin bad++; $display("FAIL rstmid_wr got en=%b a=%h d=%h want 0/00/00", wr_en, wr_addr, wr_data); end
        total++; if (frame_done !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_status got done=%b err=%b code=%b busy=%b want 0/0/00/0", frame_done, frame_err, err_code, busy); end
        idle(2);
        rst_n = 1'b1;
        clr();
        send(8'h03, t);
        send(8'h04, t);
        idle(5);
        total++; if (nwr != 0 || ne != 0 || nd != 0) begin bad++; $display("FAIL rstmid_after got wr=%0d err=%0d done=%0d want 0/0/0", nwr, ne, nd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    endtask

    task automatic test_exclusive();
        total++; if (nboth != 0) begin bad++; $display("FAIL done_err_overlap got=%0d want=0", nboth); end
    endtask

    initial begin
        test_reset();
        test_noise();
`ifndef FRAME_CHECKSUM_EN
        test_basic();
`else
        test_chk_ok();
        test_chk_bad();
`endif
        test_wrap();
        test_len_err();
        test_timeout();
        test_late_byte();
        test_reset_mid();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
